mem_access_stage: RTL
=====================

# mem_access_stage

Memory-stage load/store unit between the execute/memory pipeline register and `mem_writeback_pipe`. It turns the MEM-stage control and address into a request/grant/rvalid data-bus transaction, stalls the pipeline until the access completes, and produces the formatted load word on `rd`. It also drives the gated register-write flag that the writeback pipe captures.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data/address width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data, right-aligned.
- `MemWriteM`  in  1  store instruction in MEM.
- `ResultSrcM`  in  2  `2'b01` marks a load.
- `funct3M`  in  3  access size/sign.
- `RegWriteM`  in  1  register write request from EX/MEM.
- `rd`  out  32  formatted load data. Feeds the writeback pipe.
- `RegWriteGatedM`  out  1  equals `RegWriteM & ~StallM`.
- `StallM`  out  1  freezes F/D/E/M and bubbles WB.
- `MisalignM`  out  1  one-cycle flag for a misaligned access.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  32  word address, `{ALUResultM[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.

## Operation
- Access = load or `MemWriteM`. Load and store together is illegal; the store wins.
- Alignment:
  - Word accesses require `addr[1:0]==0`.
  - Halfword accesses require `addr[0]==0`.
  - Byte accesses are always aligned.
  - A misaligned access issues no request, pulses `MisalignM` for one cycle, sets `rd=0`, and does not stall.
- FSM states are IDLE, REQ, WAIT_R and DONE.
  - IDLE: an aligned access drives `mem_req=1` combinationally. On `gnt`, a load goes to WAIT_R and a store goes to DONE. With no `gnt`, the FSM goes to REQ.
  - REQ: holds `mem_req`, `addr`, `be` and `wdata` stable until `gnt`, then moves as in IDLE.
  - WAIT_R: on `rvalid`, registers the formatted data and goes to DONE. `rvalid` may arrive any number of cycles later.
  - DONE: `StallM=0` and `rd` = registered data. The next state is unconditionally IDLE, so the same instruction never re-issues.
- `StallM` = (IDLE & aligned access) | REQ | WAIT_R.
- Store lanes:
  - SB (000): `be = 1<<addr[1:0]`, with the byte replicated across all four lanes.
  - SH (001): `be = addr[1] ? 1100 : 0011`, with the halfword replicated.
  - SW (010): `be = 1111`.
- Load formatting selects the byte/half by `addr[1:0]`:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the word through.
  - Any other `funct3` returns 0.
- `rvalid` seen in IDLE, REQ or DONE is ignored.
- `rd` is 0 whenever the FSM is not in DONE.

## Timing
- Reset values: state IDLE, registered data 0, `rd` 0, `mem_req` 0, `StallM` 0, `MisalignM` 0, `RegWriteGatedM` 0 while `RegWriteM=0`.
- Reset mid-transaction returns the FSM to IDLE immediately and drops `mem_req`. A pending `rvalid` after reset is discarded.
- Zero-wait bus (`gnt` in the request cycle, `rvalid` one cycle later):
  - A load occupies MEM for 3 cycles, 2 of them stalled.
  - A store occupies MEM for 2 cycles, 1 of them stalled.
- Each extra cycle without `gnt` or `rvalid` adds one stall cycle.
- `rd` is valid exactly in the DONE cycle. `mem_writeback_pipe` captures it on the edge that ends DONE.
- `mem_req`, `mem_be`, `mem_wdata`, `StallM` and `MisalignM` are combinational from inputs and state. There is no combinational path from `mem_rdata` to `rd`.

## Structure
- Package `lsu_pkg` holds:
  - the state enum `lsu_state_t`;
  - the `funct3` localparams (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`);
  - the `RESULT_SRC_MEM` constant `2'b01`.
- Sub-module `load_align`: combinational lane select and sign/zero extension, taking `(rdata, addr[1:0], funct3)` and producing `data`. It is instantiated once, ahead of the data register.

## Test plan
- Zero-wait LW at `0x100`, `rdata=0xDEADBEEF` -> `StallM` high for 2 cycles, then `rd=0xDEADBEEF` in DONE, `RegWriteGatedM=0` during the stall.
- LB at `0x103` and LBU at `0x103`, `rdata=0x80112233` -> `rd=0xFFFFFF80` and `rd=0x00000080` respectively.
- SH at `0x102`, data `0x0000ABCD`, `gnt` delayed 3 cycles -> `mem_be=1100` and `mem_wdata=0xABCDABCD`, both held stable for 4 cycles, then one DONE cycle.
- LW at `0x101` -> no `mem_req`, `MisalignM` pulses once, `StallM=0`, `rd=0`.
- Load with `rvalid` delayed 5 cycles, with `rst` asserted in WAIT_R -> FSM returns to IDLE, `StallM=0`, and the late `rvalid` does not change `rd`.
- Back-to-back SW then LW -> two separate requests, no duplicate request from the DONE cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Access-size decode helpers live here so the FSM and lane logic agree on one definition.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    // funct3[1:0] encodes the access size: 00 byte, 01 half, anything else a full word.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from a bus read word and sign- or zero-extends it.
// Purely combinational; the caller registers the result.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        byte_lane = rdata[8*addr +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        data      = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, byte_lane};
            F3_LHU:  data = {16'd0, half_lane};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues a req/gnt/rvalid bus transaction, stalls the pipeline
// until it completes, and presents the formatted load word on rd during the DONE cycle.
module mem_access_stage
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    input  logic                    MemWriteM,
    input  logic [1:0]              ResultSrcM,
    input  logic [2:0]              funct3M,
    input  logic                    RegWriteM,
    output logic [DATA_WIDTH-1:0]   rd,
    output logic                    RegWriteGatedM,
    output logic                    StallM,
    output logic                    MisalignM,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    lsu_state_t            state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] load_data;

    logic is_load;
    logic is_access;
    logic aligned;
    logic access_ok;

    // A store that is also flagged as a load is treated as a store.
    assign is_load   = (ResultSrcM == RESULT_SRC_MEM) && !MemWriteM;
    assign is_access = is_load || MemWriteM;
    assign aligned   = is_aligned(funct3M, ALUResultM[1:0]);
    assign access_ok = is_access && aligned;

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (ALUResultM[1:0]),
        .funct3 (funct3M),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (access_ok) begin
                        if (!mem_gnt) begin
                            state <= REQ;
                        end else if (is_load) begin
                            state <= WAIT_R;
                        end else begin
                            state  <= DONE;
                            data_q <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (is_load) begin
                            state <= WAIT_R;
                        end else begin
                            state  <= DONE;
                            data_q <= '0;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        data_q <= load_data;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and stall outputs are forced low while reset is held, whatever the pipeline presents.
    assign mem_req   = !rst && (((state == IDLE) && access_ok) || (state == REQ));
    assign mem_we    = mem_req && MemWriteM;
    assign mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign mem_be    = byte_enable(funct3M, ALUResultM[1:0]);
    assign StallM    = mem_req || (!rst && (state == WAIT_R));
    assign MisalignM = !rst && (state == IDLE) && is_access && !aligned;

    always_comb begin
        mem_wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00:   mem_wdata = {4{WriteDataM[7:0]}};
            2'b01:   mem_wdata = {2{WriteDataM[15:0]}};
            default: mem_wdata = WriteDataM;
        endcase
    end

    assign rd             = (state == DONE) ? data_q : '0;
    assign RegWriteGatedM = RegWriteM && !StallM;

endmodule
